// File: rtl/ethernet_port_arbiter.sv
// ethernet_port_arbiter: per-packet grant of 2x2 switch output ports with round-robin contention.
// Optional per-port watchdog is built when ETH_ARB_TIMEOUT_EN is defined.
module ethernet_port_arbiter #(
  parameter int unsigned DEST_BIT      = 0,
  parameter int unsigned MAX_PKT_WORDS = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        sopA,
  input  logic        eopA,
  input  logic        sopB,
  input  logic        eopB,
  output logic        portAStall,
  output logic        portBStall,
  output logic        selA,
  output logic        selB,
  output logic        vldA,
  output logic        vldB,
  output logic        sopOutA,
  output logic        eopOutA,
  output logic        sopOutB,
  output logic        eopOutB,
  output logic        errTimeoutA,
  output logic        errTimeoutB
);

  localparam logic [1:0] OUT_IDLE  = 2'd0;
  localparam logic [1:0] OUT_OWN_A = 2'd1;
  localparam logic [1:0] OUT_OWN_B = 2'd2;

  localparam logic [1:0] IN_IDLE   = 2'd0;
  localparam logic [1:0] IN_ACTIVE = 2'd1;
  localparam logic [1:0] IN_DROP   = 2'd2;

  // Index 0 is port/input A, index 1 is port/input B throughout.
  logic [1:0]      sop_in, eop_in, dest;
  logic [1:0]      grant_c, active_c, timeout_c;
  logic            contend_c;
  logic [1:0][1:0] out_st_q, out_st_d, in_st_q, in_st_d;
  logic [1:0]      in_dest_q, in_dest_d;
  logic            rr_q, rr_d;
  logic [1:0]      vld_q, vld_d, sel_q, sel_d;
  logic [1:0]      sop_out_q, sop_out_d, eop_out_q, eop_out_d;
  logic            unused_bits;

  function automatic logic [1:0] own_code(input int x);
    return (x == 0) ? OUT_OWN_A : OUT_OWN_B;
  endfunction

  assign sop_in      = {sopB, sopA};
  assign eop_in      = {eopB, eopA};
  assign dest        = {~inB[DEST_BIT], ~inA[DEST_BIT]};
  assign unused_bits = ^{inA, inB, 32'(MAX_PKT_WORDS)};

  // Same-cycle grant decision; a port owned by the requester counts as free for it.
  always_comb begin
    contend_c = sop_in[0] & sop_in[1] & (dest[0] == dest[1]) &
                (out_st_q[dest[0]] == OUT_IDLE);
    for (int x = 0; x < 2; x++) begin
      grant_c[x]  = sop_in[x] &
                    ((out_st_q[dest[x]] == OUT_IDLE) | (out_st_q[dest[x]] == own_code(x))) &
                    ~(contend_c & (rr_q != 1'(x)));
      active_c[x] = (in_st_q[x] == IN_ACTIVE) & ~sop_in[x];
    end
  end

  assign portAStall = sop_in[0] & ~grant_c[0];
  assign portBStall = sop_in[1] & ~grant_c[1];

`ifdef ETH_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_PKT_WORDS + 1);

  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            err_q;
  logic                  o_sop, o_eop, o_grant;

  // Word counter per owned port; the owner's sop/eop are picked by the ownership code.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_c = '0;
    o_sop     = 1'b0;
    o_eop     = 1'b0;
    o_grant   = 1'b0;
    for (int p = 0; p < 2; p++) begin
      o_sop   = (out_st_q[p] == OUT_OWN_B) ? sop_in[1]  : sop_in[0];
      o_eop   = (out_st_q[p] == OUT_OWN_B) ? eop_in[1]  : eop_in[0];
      o_grant = (out_st_q[p] == OUT_OWN_B) ? grant_c[1] : grant_c[0];
      if (out_st_q[p] != OUT_IDLE) begin
        if (o_sop & o_grant) begin
          cnt_d[p] = '0;
        end else if (o_eop & ~o_sop) begin
          cnt_d[p] = '0;
        end else if (~o_sop & (cnt_q[p] >= CNT_W'(MAX_PKT_WORDS - 1))) begin
          timeout_c[p] = 1'b1;
          cnt_d[p]     = '0;
        end else begin
          cnt_d[p] = cnt_q[p] + CNT_W'(1);
        end
      end
    end
    for (int x = 0; x < 2; x++) begin
      if (grant_c[x]) begin
        cnt_d[dest[x]] = eop_in[x] ? '0 : CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_c;
    end
  end

  assign errTimeoutA = err_q[0];
  assign errTimeoutB = err_q[1];
`else
  assign timeout_c   = 2'b00;
  assign errTimeoutA = 1'b0;
  assign errTimeoutB = 1'b0;
`endif

  // Next-state for both FSM sets, round-robin pointer and registered output framing.
  always_comb begin
    out_st_d  = out_st_q;
    in_st_d   = in_st_q;
    in_dest_d = in_dest_q;
    rr_d      = contend_c ? ~rr_q : rr_q;
    vld_d     = '0;
    sop_out_d = '0;
    eop_out_d = '0;
    sel_d     = sel_q;
    for (int x = 0; x < 2; x++) begin
      if (active_c[x]) begin
        vld_d[in_dest_q[x]]     = 1'b1;
        sel_d[in_dest_q[x]]     = 1'(x);
        eop_out_d[in_dest_q[x]] = eop_in[x];
        if (eop_in[x]) begin
          out_st_d[in_dest_q[x]] = OUT_IDLE;
          in_st_d[x]             = IN_IDLE;
        end else if (timeout_c[in_dest_q[x]]) begin
          out_st_d[in_dest_q[x]] = OUT_IDLE;
          in_st_d[x]             = IN_DROP;
        end
      end
      if (grant_c[x]) begin
        // A new sop on an active input abandons the packet that never saw its eop.
        if (in_st_q[x] == IN_ACTIVE) begin
          out_st_d[in_dest_q[x]] = OUT_IDLE;
        end
        vld_d[dest[x]]     = 1'b1;
        sel_d[dest[x]]     = 1'(x);
        sop_out_d[dest[x]] = 1'b1;
        eop_out_d[dest[x]] = eop_in[x];
        out_st_d[dest[x]]  = eop_in[x] ? OUT_IDLE : own_code(x);
        in_st_d[x]         = eop_in[x] ? IN_IDLE : IN_ACTIVE;
        in_dest_d[x]       = dest[x];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_st_q  <= '0;
      in_st_q   <= '0;
      in_dest_q <= '0;
      rr_q      <= 1'b0;
      vld_q     <= '0;
      sel_q     <= '0;
      sop_out_q <= '0;
      eop_out_q <= '0;
    end else begin
      out_st_q  <= out_st_d;
      in_st_q   <= in_st_d;
      in_dest_q <= in_dest_d;
      rr_q      <= rr_d;
      vld_q     <= vld_d;
      sel_q     <= sel_d;
      sop_out_q <= sop_out_d;
      eop_out_q <= eop_out_d;
    end
  end

  assign vldA    = vld_q[0];
  assign vldB    = vld_q[1];
  assign selA    = sel_q[0];
  assign selB    = sel_q[1];
  assign sopOutA = sop_out_q[0];
  assign sopOutB = sop_out_q[1];
  assign eopOutA = eop_out_q[0];
  assign eopOutB = eop_out_q[1];

endmodule

// File: tb/tb_ethernet_port_arbiter.sv
// Scoreboard bench for ethernet_port_arbiter: directed packets push expected framing,
// a negedge monitor pops and compares per output port.
module tb_ethernet_port_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic [31:0] inA, inB;
  logic        sopA, eopA, sopB, eopB;
  logic        portAStall, portBStall, selA, selB, vldA, vldB;
  logic        sopOutA, eopOutA, sopOutB, eopOutB, errTimeoutA, errTimeoutB;

  always #5 clk = ~clk;

  ethernet_port_arbiter #(.DEST_BIT(0), .MAX_PKT_WORDS(4)) dut (
    .clk(clk), .resetN(resetN), .inA(inA), .inB(inB),
    .sopA(sopA), .eopA(eopA), .sopB(sopB), .eopB(eopB),
    .portAStall(portAStall), .portBStall(portBStall),
    .selA(selA), .selB(selB), .vldA(vldA), .vldB(vldB),
    .sopOutA(sopOutA), .eopOutA(eopOutA), .sopOutB(sopOutB), .eopOutB(eopOutB),
    .errTimeoutA(errTimeoutA), .errTimeoutB(errTimeoutB)
  );

  localparam logic [31:0] A1 = 32'hFEDBEEF1;  // dest A
  localparam logic [31:0] A2 = 32'hFEDBEEF2;  // dest B
  localparam logic [31:0] B1 = 32'hDEC0DED1;  // dest A
  localparam logic [31:0] B2 = 32'hDEC0DED2;  // dest B

  // Expected port output {vld, sel, sop, eop}
  localparam logic [3:0] NO = 4'b0000;
  localparam logic [3:0] SA = 4'b1010, MA = 4'b1000, EA = 4'b1001, WA = 4'b1011;
  localparam logic [3:0] SB = 4'b1110, MB = 4'b1100, EB = 4'b1101, WB = 4'b1111;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  exp_t qa[$], qb[$];
  int   qta[$], qtb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every negedge each port either matches the queued entry for this cycle or is idle.
  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      cmp("portA", {12'd0, vldA, selA, sopOutA, eopOutA}, {12'd0, e.val});
    end else begin
      cmp("portA idle", {13'd0, vldA, sopOutA, eopOutA}, 16'd0);
    end
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      cmp("portB", {12'd0, vldB, selB, sopOutB, eopOutB}, {12'd0, e.val});
    end else begin
      cmp("portB idle", {13'd0, vldB, sopOutB, eopOutB}, 16'd0);
    end
    if (qta.size() > 0 && qta[0] == cyc) begin
      void'(qta.pop_front());
      cmp("errTimeoutA", {15'd0, errTimeoutA}, 16'd1);
    end else begin
      cmp("errTimeoutA idle", {15'd0, errTimeoutA}, 16'd0);
    end
    if (qtb.size() > 0 && qtb[0] == cyc) begin
      void'(qtb.pop_front());
      cmp("errTimeoutB", {15'd0, errTimeoutB}, 16'd1);
    end else begin
      cmp("errTimeoutB idle", {15'd0, errTimeoutB}, 16'd0);
    end
  end

  function automatic logic [15:0] all_outs();
    return {6'd0, vldA, vldB, selA, selB, sopOutA, eopOutA, sopOutB, eopOutB,
            errTimeoutA, errTimeoutB};
  endfunction

  // Drive one cycle of inputs at posedge+1, check stalls, queue the next-edge expectations.
  task automatic step(input logic sa, input logic ea, input logic [31:0] da,
                      input logic sb, input logic eb, input logic [31:0] db,
                      input logic [1:0] stl, input logic [3:0] xa, input logic [3:0] xb,
                      input logic [1:0] xto);
    exp_t e;
    sopA = sa; eopA = ea; inA = da;
    sopB = sb; eopB = eb; inB = db;
    #1;
    cmp("stall{A,B}", {14'd0, portAStall, portBStall}, {14'd0, stl});
    e.cyc = cyc + 1;
    if (xa[3]) begin e.val = xa; qa.push_back(e); end
    if (xb[3]) begin e.val = xb; qb.push_back(e); end
    if (xto[1]) qta.push_back(cyc + 1);
    if (xto[0]) qtb.push_back(cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 2'b00, NO, NO, 2'b00);
  endtask

  task automatic do_reset();
    sopA = 1'b0; eopA = 1'b0; inA = '0;
    sopB = 1'b0; eopB = 1'b0; inB = '0;
    resetN = 1'b0;
    #2;
    cmp("reset outputs", all_outs(), 16'd0);
    resetN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0;
    sopA = 1'b0; eopA = 1'b0; inA = '0;
    sopB = 1'b0; eopB = 1'b0; inB = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Parallel, no contention
    step(1, 0, A1, 1, 0, B2, 2'b00, SA, SB, 2'b00);
    step(0, 1, '0, 0, 1, '0, 2'b00, EA, EB, 2'b00);
    idle();

    // Cross traffic
    step(1, 0, A2, 1, 0, B1, 2'b00, SB, SA, 2'b00);
    step(0, 1, '0, 0, 1, '0, 2'b00, EB, EA, 2'b00);
    idle();

    // Contention on port A, round-robin flips
    do_reset();
    step(1, 0, A1, 1, 0, B1, 2'b01, SA, NO, 2'b00);
    step(0, 1, '0, 1, 0, B1, 2'b01, EA, NO, 2'b00);
    step(0, 0, '0, 1, 0, B1, 2'b00, SB, NO, 2'b00);
    step(0, 0, '0, 0, 1, '0, 2'b00, EB, NO, 2'b00);
    step(1, 0, A1, 1, 0, B1, 2'b10, SB, NO, 2'b00);
    step(1, 0, A1, 0, 1, '0, 2'b10, EB, NO, 2'b00);
    step(1, 0, A1, 0, 0, '0, 2'b00, SA, NO, 2'b00);
    step(0, 1, '0, 0, 0, '0, 2'b00, EA, NO, 2'b00);
    idle();

    // Single-word packet then immediate competing sop
    step(1, 1, A1, 0, 0, '0, 2'b00, WA, NO, 2'b00);
    step(0, 0, '0, 1, 1, B1, 2'b00, WB, NO, 2'b00);
    idle();

    // Competing sop during the owner's eop cycle
    step(1, 0, A2, 0, 0, '0, 2'b00, NO, SA, 2'b00);
    step(0, 1, '0, 1, 0, B2, 2'b01, NO, EA, 2'b00);
    step(0, 0, '0, 1, 0, B2, 2'b00, NO, SB, 2'b00);
    step(0, 0, '0, 0, 1, '0, 2'b00, NO, EB, 2'b00);

    // Back-to-back packets from one input
    step(1, 1, A1, 0, 0, '0, 2'b00, WA, NO, 2'b00);
    step(1, 1, A1, 0, 0, '0, 2'b00, WA, NO, 2'b00);
    step(1, 0, A2, 0, 0, '0, 2'b00, NO, SA, 2'b00);
    step(0, 1, '0, 0, 0, '0, 2'b00, NO, EA, 2'b00);
    step(1, 1, A2, 0, 0, '0, 2'b00, NO, WA, 2'b00);

    // Missing eop: new sop releases the old port
    step(1, 0, A1, 0, 0, '0, 2'b00, SA, NO, 2'b00);
    step(1, 0, A2, 0, 0, '0, 2'b00, NO, SA, 2'b00);
    step(0, 1, '0, 1, 1, B1, 2'b00, WB, EA, 2'b00);

    // Words from idle inputs are ignored
    step(0, 1, '0, 0, 1, '0, 2'b00, NO, NO, 2'b00);
    step(0, 0, A1, 0, 0, B1, 2'b00, NO, NO, 2'b00);

    // Async reset mid-packet after a contended grant
    step(1, 0, A1, 1, 0, B1, 2'b01, SA, NO, 2'b00);
    #5;
    sopA = 1'b0; eopA = 1'b0; inA = '0;
    sopB = 1'b0; eopB = 1'b0; inB = '0;
    resetN = 1'b0;
    #1;
    cmp("async reset", all_outs(), 16'd0);
    #1;
    resetN = 1'b1;
    @(posedge clk);
    #1;
    step(0, 1, '0, 0, 0, '0, 2'b00, NO, NO, 2'b00);
    step(1, 0, A1, 1, 0, B1, 2'b01, SA, NO, 2'b00);
    step(0, 1, '0, 1, 0, B1, 2'b01, EA, NO, 2'b00);
    step(0, 0, '0, 1, 1, B1, 2'b00, WB, NO, 2'b00);
    idle();

`ifdef ETH_ARB_TIMEOUT_EN
    // Watchdog with MAX_PKT_WORDS=4
    step(1, 0, A1, 0, 0, '0, 2'b00, SA, NO, 2'b00);
    step(0, 0, '0, 0, 0, '0, 2'b00, MA, NO, 2'b00);
    step(0, 0, '0, 0, 0, '0, 2'b00, MA, NO, 2'b00);
    step(0, 0, '0, 0, 0, '0, 2'b00, MA, NO, 2'b10);
    step(0, 0, '0, 0, 0, '0, 2'b00, NO, NO, 2'b00);
    step(0, 1, '0, 0, 0, '0, 2'b00, NO, NO, 2'b00);
    step(1, 1, A1, 0, 0, '0, 2'b00, WA, NO, 2'b00);
    idle();
`endif

    repeat (3) idle();

    checks++;
    if (qa.size() + qb.size() + qta.size() + qtb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never seen, required 0",
               qa.size() + qb.size() + qta.size() + qtb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
